// File: rtl/vanilla_wb_scheduler_pkg.sv
`default_nettype none
// ==========================================================================
// vanilla_wb_scheduler_pkg : writeback source encoding and starve counter width
// Revision: 1.0
// ==========================================================================
package vanilla_wb_scheduler_pkg;

  typedef enum logic [1:0] {
    e_wb_pipe   = 2'd0,
    e_wb_remote = 2'd1,
    e_wb_long   = 2'd2
  } wb_src_e;

  localparam int c_starve_cnt_width = 4;

endpackage
`default_nettype wire

// File: rtl/vanilla_wb_scheduler_if.sv
`default_nettype none
// ==========================================================================
// vanilla_wb_scheduler_if : writeback sources, RF write port, scoreboard clear
// Revision: 1.0
// ==========================================================================
interface vanilla_wb_scheduler_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
);
  logic                        pipe_v_i;
  logic [reg_addr_width_p-1:0] pipe_id_i;
  logic [data_width_p-1:0]     pipe_data_i;
  logic                        remote_v_i;
  logic [reg_addr_width_p-1:0] remote_id_i;
  logic [data_width_p-1:0]     remote_data_i;
  logic                        remote_yumi_o;
  logic                        long_v_i;
  logic [reg_addr_width_p-1:0] long_id_i;
  logic [data_width_p-1:0]     long_data_i;
  logic                        long_yumi_o;
  logic                        rf_w_v_o;
  logic [reg_addr_width_p-1:0] rf_w_addr_o;
  logic [data_width_p-1:0]     rf_w_data_o;
  logic                        sb_clear_o;
  logic [reg_addr_width_p-1:0] sb_clear_id_o;
  logic                        stall_pipe_o;

  modport slave (
    input  pipe_v_i, pipe_id_i, pipe_data_i,
    input  remote_v_i, remote_id_i, remote_data_i,
    input  long_v_i, long_id_i, long_data_i,
    output remote_yumi_o, long_yumi_o,
    output rf_w_v_o, rf_w_addr_o, rf_w_data_o,
    output sb_clear_o, sb_clear_id_o, stall_pipe_o
  );

  modport master (
    output pipe_v_i, pipe_id_i, pipe_data_i,
    output remote_v_i, remote_id_i, remote_data_i,
    output long_v_i, long_id_i, long_data_i,
    input  remote_yumi_o, long_yumi_o,
    input  rf_w_v_o, rf_w_addr_o, rf_w_data_o,
    input  sb_clear_o, sb_clear_id_o, stall_pipe_o
  );
endinterface
`default_nettype wire

// File: rtl/vanilla_wb_scheduler_rr.sv
`default_nettype none
// ==========================================================================
// vanilla_wb_scheduler_rr : 2-way round-robin, bit 0 = remote, bit 1 = long
// Revision: 1.0
// ==========================================================================
module vanilla_wb_scheduler_rr (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [1:0] reqs_i,
  output logic [1:0] grants_o
);
  // ptr_q == 0 favours remote; it only moves on a contended grant
  logic ptr_q, ptr_d;

  always_comb begin
    grants_o = 2'b00;
    ptr_d    = ptr_q;
    if (en_i) begin
      unique case (reqs_i)
        2'b01:   grants_o = 2'b01;
        2'b10:   grants_o = 2'b10;
        2'b11: begin
          grants_o = ptr_q ? 2'b10 : 2'b01;
          ptr_d    = ~ptr_q;
        end
        default: grants_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/vanilla_wb_scheduler.sv
`default_nettype none
// ==========================================================================
// vanilla_wb_scheduler : RF write-port arbiter (pipe > remote/long RR) + sb clear
// Revision: 1.0
// ==========================================================================
module vanilla_wb_scheduler
  import vanilla_wb_scheduler_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int zero_reg_p       = 1,
  parameter int starve_limit_p   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  vanilla_wb_scheduler_if.slave  wb
);
  localparam logic [c_starve_cnt_width-1:0] c_limit = c_starve_cnt_width'(starve_limit_p);

  logic [c_starve_cnt_width-1:0] starve_cnt_q, starve_cnt_d;
  logic                          stall_q, stall_d;
  logic                          w_pipe_g, w_side_g, w_grant_v;
  logic [1:0]                    w_grants;
  wb_src_e                       w_src;
  logic [reg_addr_width_p-1:0]   w_id;
  logic [data_width_p-1:0]       w_data;

  // Nothing is granted during reset so in-flight sources are never acked
  assign w_pipe_g = wb.pipe_v_i & ~reset_i;

  vanilla_wb_scheduler_rr u_rr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (~wb.pipe_v_i & ~reset_i),
    .reqs_i   ({wb.long_v_i, wb.remote_v_i}),
    .grants_o (w_grants)
  );

  assign w_side_g  = |w_grants;
  assign w_grant_v = w_pipe_g | w_side_g;

  always_comb begin
    if (w_grants[1])      w_src = e_wb_long;
    else if (w_grants[0]) w_src = e_wb_remote;
    else                  w_src = e_wb_pipe;
    case (w_src)
      e_wb_remote: begin w_id = wb.remote_id_i; w_data = wb.remote_data_i; end
      e_wb_long:   begin w_id = wb.long_id_i;   w_data = wb.long_data_i;   end
      default:     begin w_id = wb.pipe_id_i;   w_data = wb.pipe_data_i;   end
    endcase
  end

  assign wb.rf_w_v_o      = w_grant_v & ~((zero_reg_p != 0) && (w_id == '0));
  assign wb.rf_w_addr_o   = w_id;
  assign wb.rf_w_data_o   = w_data;
  assign wb.sb_clear_o    = w_side_g;
  assign wb.sb_clear_id_o = w_id;
  assign wb.remote_yumi_o = w_grants[0];
  assign wb.long_yumi_o   = w_grants[1];
  assign wb.stall_pipe_o  = stall_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    stall_d      = stall_q;
    if (w_side_g) begin
      starve_cnt_d = '0;
      stall_d      = 1'b0;
    end else begin
      if ((wb.remote_v_i | wb.long_v_i) & wb.pipe_v_i & (starve_cnt_q != c_limit))
        starve_cnt_d = starve_cnt_q + 1'b1;
      if (starve_cnt_d == c_limit)
        stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

`ifndef SYNTHESIS
  a_pipe_while_stalled: assert property (@(posedge clk_i) disable iff (reset_i)
    !(wb.pipe_v_i && stall_q));
  a_remote_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (wb.remote_v_i && !w_grants[0]) |=>
      (wb.remote_v_i && $stable(wb.remote_id_i) && $stable(wb.remote_data_i)));
  a_long_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (wb.long_v_i && !w_grants[1]) |=>
      (wb.long_v_i && $stable(wb.long_id_i) && $stable(wb.long_data_i)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_vanilla_wb_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_vanilla_wb_scheduler : vector table plus clear scoreboard, int/float pair
// Revision: 1.0
// ==========================================================================
module tb_vanilla_wb_scheduler;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic        pv;  logic [4:0] pid; logic [31:0] pdat;
    logic        rv;  logic [4:0] rid; logic [31:0] rdat;
    logic        lv;  logic [4:0] lid; logic [31:0] ldat;
    logic        e_rfi; logic e_rff; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_clr; logic [4:0] e_clr_id; logic e_ry; logic e_ly; logic [3:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pipe_v = 1'b0, remote_v = 1'b0, long_v = 1'b0;
  logic [4:0]  pipe_id = '0, remote_id = '0, long_id = '0;
  logic [31:0] pipe_data = '0, remote_data = '0, long_data = '0;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;
  bit  got_ry  = 1'b0, got_ly = 1'b0;
  wb_t rem_q[$], long_q[$], exp_q[$];
  wb_t e_mon;
  vec_t vecs[9];

  always #5 clk = ~clk;

  vanilla_wb_scheduler_if #(.data_width_p(32), .reg_addr_width_p(5)) bus_int ();
  vanilla_wb_scheduler_if #(.data_width_p(32), .reg_addr_width_p(5)) bus_flt ();

  assign bus_int.pipe_v_i = pipe_v;     assign bus_flt.pipe_v_i = pipe_v;
  assign bus_int.pipe_id_i = pipe_id;   assign bus_flt.pipe_id_i = pipe_id;
  assign bus_int.pipe_data_i = pipe_data;     assign bus_flt.pipe_data_i = pipe_data;
  assign bus_int.remote_v_i = remote_v;       assign bus_flt.remote_v_i = remote_v;
  assign bus_int.remote_id_i = remote_id;     assign bus_flt.remote_id_i = remote_id;
  assign bus_int.remote_data_i = remote_data; assign bus_flt.remote_data_i = remote_data;
  assign bus_int.long_v_i = long_v;           assign bus_flt.long_v_i = long_v;
  assign bus_int.long_id_i = long_id;         assign bus_flt.long_id_i = long_id;
  assign bus_int.long_data_i = long_data;     assign bus_flt.long_data_i = long_data;

  vanilla_wb_scheduler #(.data_width_p(32), .reg_addr_width_p(5), .zero_reg_p(1), .starve_limit_p(4))
    dut_int (.clk_i(clk), .reset_i(reset), .wb(bus_int.slave));
  vanilla_wb_scheduler #(.data_width_p(32), .reg_addr_width_p(5), .zero_reg_p(0), .starve_limit_p(4))
    dut_flt (.clk_i(clk), .reset_i(reset), .wb(bus_flt.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every scoreboard clear pops the next expected {id,data}
  always @(negedge clk) begin
    if (mon_en && bus_flt.sb_clear_o) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_clear: got id %0d, expected no clear", bus_flt.sb_clear_id_o);
      end else begin
        e_mon = exp_q.pop_front();
        check("sb_clear_id_flt", 32'(bus_flt.sb_clear_id_o), 32'(e_mon.id));
        check("sb_clear_id_int", 32'(bus_int.sb_clear_id_o), 32'(e_mon.id));
        check("sb_rf_w_v_flt", 32'(bus_flt.rf_w_v_o), 32'd1);
        check("sb_rf_w_data_flt", bus_flt.rf_w_data_o, e_mon.data);
      end
    end
  end

  function automatic void drive_srcs();
    remote_v = (rem_q.size() != 0);
    if (remote_v) begin remote_id = rem_q[0].id; remote_data = rem_q[0].data; end
    long_v = (long_q.size() != 0);
    if (long_v) begin long_id = long_q[0].id; long_data = long_q[0].data; end
  endfunction

  task automatic tick(input logic pv, input logic [4:0] pid, input logic [31:0] pdat);
    @(posedge clk); #1;
    if (got_ry) void'(rem_q.pop_front());
    if (got_ly) void'(long_q.pop_front());
    pipe_v = pv; pipe_id = pid; pipe_data = pdat;
    drive_srcs();
    @(negedge clk);
    got_ry = bus_flt.remote_yumi_o;
    got_ly = bus_flt.long_yumi_o;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; pipe_v = 1'b0;
    rem_q.delete(); long_q.delete(); drive_srcs();
    got_ry = 1'b0; got_ly = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (rem_q.size() != 0 || long_q.size() != 0); i++) tick(1'b0, 5'd0, 32'd0);
    if (rem_q.size() != 0 || long_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d sources pending, expected 0", name, rem_q.size() + long_q.size());
    end
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    //        pv pid   pdat          rv rid   rdat          lv lid    ldat          rfi rff addr  data          clr cid  ry ly cnt
    vecs[0] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 0, 4'd0};
    vecs[1] = '{0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 0, 4'd0};
    vecs[2] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd12, 32'h12345678, 1, 1, 5'd12, 32'h12345678, 1, 5'd12, 0, 1, 4'd0};
    vecs[3] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h0000CAFE, 0, 5'd0,  32'h0,        0, 1, 5'd0, 32'h0000CAFE, 1, 5'd0, 1, 0, 4'd0};
    vecs[4] = '{1, 5'd9, 32'h99,       1, 5'd3, 32'h33,       0, 5'd0,  32'h0,        1, 1, 5'd9, 32'h99,       0, 5'd0, 0, 0, 4'd1};
    vecs[5] = '{1, 5'd0, 32'h55,       0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 1, 5'd0, 32'h55,       0, 5'd0, 0, 0, 4'd0};
    vecs[6] = '{0, 5'd0, 32'h0,        1, 5'd3, 32'hA,        1, 5'd7,  32'hB,        1, 1, 5'd3, 32'hA,        1, 5'd3, 1, 0, 4'd0};
    vecs[7] = '{1, 5'd2, 32'h22,       1, 5'd3, 32'hA,        1, 5'd7,  32'hB,        1, 1, 5'd2, 32'h22,       0, 5'd0, 0, 0, 4'd1};
    vecs[8] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd0,  32'h77,       0, 1, 5'd0, 32'h77,       1, 5'd0, 0, 1, 4'd0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(bus_int.stall_pipe_o), 32'd0);
    check("rst_cnt", 32'(dut_int.starve_cnt_q), 32'd0);
    check("rst_rf_w_v", 32'(bus_int.rf_w_v_o), 32'd0);
    check("rst_sb_clear", 32'(bus_int.sb_clear_o), 32'd0);

    // Each vector starts from reset state; a reset cycle follows it
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      {pipe_v, pipe_id, pipe_data} = {vecs[i].pv, vecs[i].pid, vecs[i].pdat};
      {remote_v, remote_id, remote_data} = {vecs[i].rv, vecs[i].rid, vecs[i].rdat};
      {long_v, long_id, long_data} = {vecs[i].lv, vecs[i].lid, vecs[i].ldat};
      @(negedge clk);
      check($sformatf("v%0d_rf_w_v_int", i), 32'(bus_int.rf_w_v_o), 32'(vecs[i].e_rfi));
      check($sformatf("v%0d_rf_w_v_flt", i), 32'(bus_flt.rf_w_v_o), 32'(vecs[i].e_rff));
      if (vecs[i].e_rff) begin
        check($sformatf("v%0d_rf_w_addr", i), 32'(bus_flt.rf_w_addr_o), 32'(vecs[i].e_addr));
        check($sformatf("v%0d_rf_w_data", i), bus_flt.rf_w_data_o, vecs[i].e_data);
      end
      check($sformatf("v%0d_sb_clear", i), 32'(bus_int.sb_clear_o), 32'(vecs[i].e_clr));
      if (vecs[i].e_clr)
        check($sformatf("v%0d_sb_clear_id", i), 32'(bus_int.sb_clear_id_o), 32'(vecs[i].e_clr_id));
      check($sformatf("v%0d_remote_yumi", i), 32'(bus_int.remote_yumi_o), 32'(vecs[i].e_ry));
      check($sformatf("v%0d_long_yumi", i), 32'(bus_int.long_yumi_o), 32'(vecs[i].e_ly));
      @(posedge clk); #1;
      check($sformatf("v%0d_cnt", i), 32'(dut_int.starve_cnt_q), 32'(vecs[i].e_cnt));
      reset = 1'b1;
      pipe_v = 1'b0; remote_v = 1'b0; long_v = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
    end

    mon_en = 1'b1;

    // Round-robin alternation: 3,7 then 8,4
    do_reset();
    rem_q.push_back('{5'd3, 32'h3003}); long_q.push_back('{5'd7, 32'h7007});
    exp_q.push_back('{5'd3, 32'h3003}); exp_q.push_back('{5'd7, 32'h7007});
    drain("rr_pair1");
    rem_q.push_back('{5'd4, 32'h4004}); long_q.push_back('{5'd8, 32'h8008});
    exp_q.push_back('{5'd8, 32'h8008}); exp_q.push_back('{5'd4, 32'h4004});
    drain("rr_pair2");

    // Same destination from both sources: two separate clears
    do_reset();
    rem_q.push_back('{5'd6, 32'h0000_0A06}); long_q.push_back('{5'd6, 32'h0000_0B06});
    exp_q.push_back('{5'd6, 32'h0000_0A06}); exp_q.push_back('{5'd6, 32'h0000_0B06});
    drain("same_id");

    // Starvation: pipe denies long for 4 cycles, stall forces the grant
    do_reset();
    long_q.push_back('{5'd11, 32'hB0B0_0011});
    exp_q.push_back('{5'd11, 32'hB0B0_0011});
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 5'd1, 32'h100 + 32'(k));
      check($sformatf("starve_c%0d_stall", k), 32'(bus_int.stall_pipe_o), 32'd0);
      check($sformatf("starve_c%0d_cnt", k), 32'(dut_int.starve_cnt_q), 32'(k - 1));
    end
    tick(1'b0, 5'd0, 32'd0);
    check("starve_stall_hi", 32'(bus_int.stall_pipe_o), 32'd1);
    check("starve_cnt_lim", 32'(dut_int.starve_cnt_q), 32'd4);
    check("starve_long_yumi", 32'(bus_int.long_yumi_o), 32'd1);
    tick(1'b0, 5'd0, 32'd0);
    check("starve_stall_lo", 32'(bus_int.stall_pipe_o), 32'd0);
    check("starve_cnt_clr", 32'(dut_int.starve_cnt_q), 32'd0);
    check("starve_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset while stalled at the limit with long still pending
    do_reset();
    long_q.push_back('{5'd13, 32'h1313_1313});
    for (int k = 1; k <= 4; k++) tick(1'b1, 5'd1, 32'h200);
    @(posedge clk); #1;
    reset = 1'b1; pipe_v = 1'b0;
    @(negedge clk);
    check("rstmid_long_yumi", 32'(bus_int.long_yumi_o), 32'd0);
    check("rstmid_sb_clear", 32'(bus_int.sb_clear_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    long_q.delete(); drive_srcs(); got_ly = 1'b0;
    @(negedge clk);
    check("rstmid_stall", 32'(bus_int.stall_pipe_o), 32'd0);
    check("rstmid_cnt", 32'(dut_int.starve_cnt_q), 32'd0);
    rem_q.push_back('{5'd1, 32'h0101}); long_q.push_back('{5'd2, 32'h0202});
    exp_q.push_back('{5'd1, 32'h0101}); exp_q.push_back('{5'd2, 32'h0202});
    drain("rstmid_rr");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
